// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: baud-rate table, the divider helper
// used by both transmitter and receiver, status-bit positions and the FSM
// state encodings.
package uart_pkg;

  // Slowest selectable baud rate; it sets the bit-counter width.
  localparam int unsigned BAUD_MIN = 1200;

  // Bit positions inside uart_status.
  localparam int STAT_TX_BUSY    = 0;
  localparam int STAT_RX_VALID   = 1;
  localparam int STAT_RX_OVERRUN = 2;
  localparam int STAT_FRAME_ERR  = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Baud rate for each 3-bit select.
  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return 32'd1200;
      3'd1:    return 32'd2400;
      3'd2:    return 32'd4800;
      3'd3:    return 32'd9600;
      3'd4:    return 32'd19200;
      3'd5:    return 32'd57600;
      3'd6:    return 32'd115200;
      default: return 32'd230400;
    endcase
  endfunction

  // Clock cycles per bit. clk_freq is always a parameter at the call site,
  // so every branch folds to a constant and only an 8-way mux remains.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [2:0]  sel);
    case (sel)
      3'd0:    return clk_freq / 32'd1200;
      3'd1:    return clk_freq / 32'd2400;
      3'd2:    return clk_freq / 32'd4800;
      3'd3:    return clk_freq / 32'd9600;
      3'd4:    return clk_freq / 32'd19200;
      3'd5:    return clk_freq / 32'd57600;
      3'd6:    return clk_freq / 32'd115200;
      default: return clk_freq / 32'd230400;
    endcase
  endfunction

endpackage

// File: rtl/uart_core_rx.sv
// UART receiver: two-flop synchronizer on rxd, falling-edge start detection,
// mid-bit sampling of an 8N1 frame, and the rx_valid / rx_overrun /
// frame_err flags with their acknowledge.
//   clk, rstb   : system clock, asynchronous active-low reset
//   rxd         : raw serial input (asynchronous to clk)
//   cfg_sel     : baud select, latched at start-bit detection
//   rcvd_ack    : one-cycle pulse clearing the three flags
//   rx_valid, rx_overrun, frame_err : receive flags
//   rcvd_byte   : last correctly received byte
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       rxd,
  input  logic [2:0] cfg_sel,
  input  logic       rcvd_ack,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic [7:0] rcvd_byte
);

  localparam int CNT_W = $clog2(CLK_FREQ / BAUD_MIN + 1);

  rx_state_t        rx_state, rx_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic             rx_fall;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] rx_div, rx_half;
  logic [2:0]       rx_bit;
  logic [2:0]       rx_sel;
  logic [7:0]       rx_shift;
  logic             rx_tick, stop_good, stop_bad;

  // Synchronizer plus one extra flop for edge detection; all idle high so
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_div  = CNT_W'(baud_div(CLK_FREQ, rx_sel));
  assign rx_half = rx_div >> 1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      // A start bit that is high again at mid-bit was only a glitch.
      RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_BREAK;
      // Wait out a held-low line before hunting for the next start edge.
      RX_BREAK: if (rx_sync) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_tick   = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (rx_state)
      RX_START:         rx_tick = (rx_cnt == rx_half - CNT_W'(1));
      RX_DATA, RX_STOP: rx_tick = (rx_cnt == rx_div - CNT_W'(1));
      default:          rx_tick = 1'b0;
    endcase
    if (rx_state == RX_STOP && rx_tick) begin
      stop_good = rx_sync;
      stop_bad  = ~rx_sync;
    end
  end

  // Bit timer restarts at every sample, so successive samples are DIV apart.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sel <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_fall) rx_sel <= cfg_sel;
        end
        RX_START, RX_DATA, RX_STOP: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
      endcase
    end
  end

  // LSB arrives first, so shift right and insert at the top.
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_sync, rx_shift[7:1]};
  end

  // A new stop-bit event takes priority over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      rcvd_byte  <= '0;
    end else begin
      if (stop_good)     rx_valid <= 1'b1;
      else if (rcvd_ack) rx_valid <= 1'b0;

      if (stop_good && (!rx_valid || rcvd_ack)) rcvd_byte <= rx_shift;

      if (stop_good && rx_valid && !rcvd_ack) rx_overrun <= 1'b1;
      else if (rcvd_ack)                      rx_overrun <= 1'b0;

      if (stop_bad)      frame_err <= 1'b1;
      else if (rcvd_ack) frame_err <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART with eight selectable baud rates. The transmitter
// FSM lives here; the receiver is the uart_rx sub-module.
//   clk, rstb      : system clock, asynchronous active-low reset
//   uart_cfg       : [2:0] baud select, [7:3] unused
//   send_byte      : byte to transmit, taken with send_valid
//   send_valid     : one-cycle send request, ignored while busy
//   rcvd_ack       : one-cycle pulse clearing the receive flags
//   rxd / txd      : serial receive / transmit lines
//   uart_status    : {4'b0, frame_err, rx_overrun, rx_valid, tx_busy}
//   uart_rcvd_byte : last correctly received byte
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [7:0] uart_cfg,
  input  logic [7:0] send_byte,
  input  logic       send_valid,
  input  logic       rcvd_ack,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] uart_status,
  output logic [7:0] uart_rcvd_byte
);

  localparam int CNT_W = $clog2(CLK_FREQ / BAUD_MIN + 1);

  tx_state_t        tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] tx_div;
  logic [2:0]       tx_bit;
  logic [2:0]       tx_sel;
  logic [7:0]       tx_shift;
  logic             tx_bit_end;
  logic             tx_busy;
  logic             rx_valid, rx_overrun, frame_err;
  logic             unused_cfg;

  assign unused_cfg = ^uart_cfg[7:3];
  assign tx_div     = CNT_W'(baud_div(CLK_FREQ, tx_sel));
  assign tx_bit_end = (tx_cnt == tx_div - CNT_W'(1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (send_valid) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // txd is decoded from the state so a reset drives the line high at once.
  always_comb begin
    txd     = 1'b1;
    tx_busy = 1'b1;
    case (tx_state)
      TX_IDLE:  tx_busy = 1'b0;
      TX_START: txd     = 1'b0;
      TX_DATA:  txd     = tx_shift[0];
      default:  txd     = 1'b1;
    endcase
  end

  // Baud select is captured with the byte so later cfg writes cannot
  // stretch or shrink the frame in flight.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sel <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      if (send_valid) tx_sel <= uart_cfg[2:0];
    end else if (tx_bit_end) begin
      tx_cnt <= '0;
      if (tx_state == TX_DATA) tx_bit <= tx_bit + 3'd1;
    end else begin
      tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_state == TX_IDLE && send_valid)      tx_shift <= send_byte;
    else if (tx_state == TX_DATA && tx_bit_end) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  uart_rx #(
    .CLK_FREQ (CLK_FREQ)
  ) u_rx (
    .clk        (clk),
    .rstb       (rstb),
    .rxd        (rxd),
    .cfg_sel    (uart_cfg[2:0]),
    .rcvd_ack   (rcvd_ack),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .rcvd_byte  (uart_rcvd_byte)
  );

  always_comb begin
    uart_status                  = '0;
    uart_status[STAT_TX_BUSY]    = tx_busy;
    uart_status[STAT_RX_VALID]   = rx_valid;
    uart_status[STAT_RX_OVERRUN] = rx_overrun;
    uart_status[STAT_FRAME_ERR]  = frame_err;
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at CLK_FREQ=1152000 (10 clocks per bit at
// baud select 6). Outputs are sampled on the falling clock edge.
module tb_uart_core;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic [7:0] uart_cfg;
  logic [7:0] send_byte;
  logic       send_valid;
  logic       rcvd_ack;
  logic       rxd;
  logic       rxd_drv;
  logic       loop_en;
  logic       txd;
  logic [7:0] uart_status;
  logic [7:0] uart_rcvd_byte;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_core #(
    .CLK_FREQ (1152000)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .uart_cfg       (uart_cfg),
    .send_byte      (send_byte),
    .send_valid     (send_valid),
    .rcvd_ack       (rcvd_ack),
    .rxd            (rxd),
    .txd            (txd),
    .uart_status    (uart_status),
    .uart_rcvd_byte (uart_rcvd_byte)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one byte and checks every bit period of txd plus the busy window.
  // With inject set, a second request (0x77) and a baud change arrive mid-frame.
  task automatic tx_frame(input logic [7:0] b, input logic [9:0] lv,
                          input bit inject, input string tag);
    int match;
    int busy_cnt;
    int idle_cnt;
    busy_cnt = 0;
    @(negedge clk);
    send_byte  = b;
    send_valid = 1'b1;
    @(negedge clk);
    send_valid = 1'b0;
    for (int p = 0; p < 10; p++) begin
      match = 0;
      for (int c = 0; c < 10; c++) begin
        if (txd === lv[p]) match++;
        if (uart_status[0] === 1'b1) busy_cnt++;
        if (inject && p == 4 && c == 3) begin
          send_byte  = 8'h77;
          send_valid = 1'b1;
          uart_cfg   = 8'h00;
        end else begin
          send_valid = 1'b0;
        end
        @(negedge clk);
      end
      chk($sformatf("%s period%0d cycles", tag, p), match, 10);
    end
    chk($sformatf("%s busy cycles", tag), busy_cnt, 100);
    chk($sformatf("%s busy after stop", tag), uart_status[0], 1'b0);
    uart_cfg = 8'h06;
    idle_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (txd === 1'b1 && uart_status[0] === 1'b0) idle_cnt++;
      @(negedge clk);
    end
    chk($sformatf("%s idle after frame", tag), idle_cnt, 12);
  endtask

  // Drives one 8N1 frame on rxd; ack_idx pulses rcvd_ack on that cycle
  // (97 lines up with the stop-bit sample), cfg_flip changes the baud
  // select halfway through.
  task automatic rx_frame(input logic [7:0] b, input bit stop,
                          input int ack_idx, input bit cfg_flip);
    logic [9:0] lv;
    lv = {stop, b, 1'b0};
    for (int i = 0; i < 100; i++) begin
      rxd_drv  = lv[i/10];
      rcvd_ack = (i == ack_idx);
      if (cfg_flip && i >= 50) uart_cfg = 8'h00;
      @(negedge clk);
    end
    rcvd_ack = 1'b0;
    uart_cfg = 8'h06;
    repeat (3) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rcvd_ack = 1'b1;
    @(negedge clk);
    rcvd_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    uart_cfg   = 8'h06;
    send_byte  = 8'h00;
    send_valid = 1'b0;
    rcvd_ack   = 1'b0;
    rxd_drv    = 1'b1;
    loop_en    = 1'b0;
    #1 rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset txd", txd, 1'b1);
    chk("reset status", uart_status, 8'h00);
    chk("reset rcvd_byte", uart_rcvd_byte, 8'h00);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset status", uart_status, 8'h00);

    // 0xA5: start, 1,0,1,0,0,1,0,1, stop
    tx_frame(8'hA5, 10'b1_1010_0101_0, 1'b0, "txA5");
    // 0x5A with a rejected 0x77 request and a cfg change mid-frame
    tx_frame(8'h5A, 10'b1_0101_1010_0, 1'b1, "tx5A");

    // Loopback of 0x3C
    loop_en = 1'b1;
    @(negedge clk);
    send_byte  = 8'h3C;
    send_valid = 1'b1;
    @(negedge clk);
    send_valid = 1'b0;
    cyc = 1;
    while (uart_status[1] !== 1'b1 && cyc <= 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("loopback rx_valid within 100", (cyc <= 100), 1'b1);
    chk("loopback byte", uart_rcvd_byte, 8'h3C);
    repeat (5) @(negedge clk);
    chk("loopback status before ack", uart_status, 8'h02);
    ack_pulse();
    chk("loopback status after ack", uart_status, 8'h00);
    chk("loopback byte kept", uart_rcvd_byte, 8'h3C);
    loop_en = 1'b0;

    // Overrun: 0x11 then 0x22 (with a mid-frame cfg change) without ack
    rx_frame(8'h11, 1'b1, -1, 1'b0);
    chk("rx 0x11 status", uart_status, 8'h02);
    chk("rx 0x11 byte", uart_rcvd_byte, 8'h11);
    rx_frame(8'h22, 1'b1, -1, 1'b1);
    chk("overrun status", uart_status, 8'h06);
    chk("overrun byte kept", uart_rcvd_byte, 8'h11);
    ack_pulse();
    chk("overrun ack status", uart_status, 8'h00);

    // Framing error on 0x55 with the line held low afterwards
    rx_frame(8'h55, 1'b0, -1, 1'b0);
    chk("frame_err status", uart_status, 8'h08);
    chk("frame_err byte not loaded", uart_rcvd_byte, 8'h11);
    chk("frame_err in BREAK", dut.u_rx.rx_state, RX_BREAK);
    repeat (20) @(negedge clk);
    chk("still BREAK while low", dut.u_rx.rx_state, RX_BREAK);
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
    chk("BREAK left on high", dut.u_rx.rx_state, RX_IDLE);
    chk("frame_err sticky", uart_status, 8'h08);
    ack_pulse();
    chk("frame_err ack", uart_status, 8'h00);

    // Ack coincident with a good stop sample
    rx_frame(8'h11, 1'b1, -1, 1'b0);
    chk("pre-ack valid", uart_status, 8'h02);
    rx_frame(8'h22, 1'b1, 97, 1'b0);
    chk("ack+good status", uart_status, 8'h02);
    chk("ack+good byte", uart_rcvd_byte, 8'h22);

    // Ack coincident with a bad stop sample
    rx_frame(8'h55, 1'b0, 97, 1'b0);
    chk("ack+bad status", uart_status, 8'h08);
    chk("ack+bad byte", uart_rcvd_byte, 8'h22);
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
    ack_pulse();
    chk("ack+bad cleared", uart_status, 8'h00);

    // 3-cycle glitch on idle line
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch status", uart_status, 8'h00);
    chk("glitch rx idle", dut.u_rx.rx_state, RX_IDLE);
    chk("glitch byte", uart_rcvd_byte, 8'h22);

    // Reset during data bit 4 of 0x0F (bit 4 is 0)
    @(negedge clk);
    send_byte  = 8'h0F;
    send_valid = 1'b1;
    @(negedge clk);
    send_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre-reset bit4 txd", txd, 1'b0);
    rstb = 1'b0;
    #1;
    chk("mid-frame reset txd", txd, 1'b1);
    chk("mid-frame reset status", uart_status, 8'h00);
    chk("mid-frame reset byte", uart_rcvd_byte, 8'h00);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    chk("after reset txd idle", txd, 1'b1);
    // 0xC3: start, 1,1,0,0,0,0,1,1, stop
    tx_frame(8'hC3, 10'b1_1100_0011_0, 1'b0, "txC3");
    chk("no rx from tx activity", uart_status, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rstb  input  1  asynchronous, active-low reset.
REQ-004 uart_cfg  input  8  bits[2:0] select the baud rate; bits[7:3] are ignored.
REQ-005 send_byte  input  8  byte to transmit.
REQ-006 send_valid  input  1  one-cycle pulse requesting transmission of send_byte.
REQ-007 rcvd_ack  input  1  one-cycle pulse clearing the receive flags (issued by the register read of offset 0).
REQ-008 rxd  input  1  serial receive line, asynchronous to clk.
REQ-009 txd  output  1  serial transmit line.
REQ-010 uart_status  output  8  bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun, bit3 frame_err, bits[7:4] zero.
REQ-011 uart_rcvd_byte  output  8  last correctly received byte.

Function
REQ-012 Baud select 0..7 SHALL map to 1200, 2400, 4800, 9600, 19200, 57600, 115200 and 230400; DIV = floor(CLK_FREQ/baud), computed at elaboration time.
REQ-013 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly DIV clk cycles.
REQ-014 TX FSM SHALL use states IDLE, START, DATA, STOP; send_valid in IDLE latches send_byte and uart_cfg[2:0], and txd goes low on the next clock edge.
REQ-015 tx_busy SHALL be 1 from the cycle after an accepted send_valid until the last cycle of the stop bit inclusive, and SHALL be 0 in IDLE.
REQ-016 send_valid while tx_busy=1 SHALL be ignored (no queuing), and the current frame SHALL be unaffected.
REQ-017 A uart_cfg change mid-frame SHALL NOT affect the frame in progress; TX and RX each latch the select at frame start.
REQ-018 rxd SHALL pass through a two-flop synchronizer before use.
REQ-019 RX FSM SHALL use states IDLE, START, DATA, STOP, BREAK; a synchronized falling edge in IDLE enters START.
REQ-020 In START, rxd SHALL be sampled after DIV/2 cycles; if the sample is 0, go to DATA; if 1, treat it as a glitch and return to IDLE with no flag change.
REQ-021 In DATA, each bit SHALL be sampled DIV cycles after the previous sample; after 8 samples, go to STOP and sample once more after DIV cycles.
REQ-022 Stop sample 1 with rx_valid=0: load uart_rcvd_byte, set rx_valid, return to IDLE.
REQ-023 Stop sample 1 with rx_valid=1: discard the new byte, keep uart_rcvd_byte, set rx_overrun, return to IDLE.
REQ-024 Stop sample 0: set frame_err, do not load the byte, enter BREAK; leave BREAK to IDLE when the synchronized rxd is 1.
REQ-025 rcvd_ack SHALL clear rx_valid, rx_overrun and frame_err on the next edge.
REQ-026 If rcvd_ack and a good stop sample occur in the same cycle, the new byte SHALL load, rx_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-027 If rcvd_ack and a bad stop sample occur in the same cycle, frame_err SHALL end at 1 (the new event wins).
REQ-028 TX and RX SHALL operate fully independently (full duplex); loopback of txd to rxd SHALL work.
REQ-029 Bit counters SHALL be wide enough for DIV at select 0, with no wrap-around inside a bit.

Reset
REQ-030 While rstb=0: txd=1, both FSMs in IDLE, all status bits 0, uart_rcvd_byte=0, synchronizer flops=1, all counters 0.
REQ-031 Reset assertion mid-frame SHALL abort immediately; after release, the line is idle-high and no partial byte is reported.

Structure
REQ-032 Shared package uart_pkg SHALL hold the baud rate table, status bit index constants and FSM state encodings.
REQ-033 The receiver (synchronizer plus RX FSM) SHALL be one sub-module, uart_rx; the TX FSM SHALL stay in uart_core.

Verification (CLK_FREQ=1152000, so DIV=10 at select 6)
REQ-034 cfg=6, send_valid with 0xA5 -> txd low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles; tx_busy high for exactly 100 cycles.
REQ-035 Loopback txd->rxd, send 0x3C -> rx_valid=1 and uart_rcvd_byte=0x3C within 100 cycles of frame start; rcvd_ack -> status bits[3:0]=0 next cycle.
REQ-036 Send two bytes 0x11 then 0x22 into RX without an ack -> uart_rcvd_byte=0x11, rx_overrun=1.
REQ-037 Drive a frame with stop bit 0 and 0x55 data -> frame_err=1, rx_valid=0, byte not loaded; RX stays in BREAK until rxd=1.
REQ-038 3-cycle low glitch on idle rxd -> no flag change, RX back in IDLE; send_valid with 0x77 during an active TX -> ignored, original frame intact.
REQ-039 Assert rstb mid-TX at bit 4 -> txd=1 immediately, tx_busy=0, and a new send_valid after release produces a clean frame.
